// File: rtl/trojan_resp_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : trojan_resp_analyzer
// Brief    : Captures one response bit per exhaustive input pattern, in order,
//            and compares the captured vector against a golden vector.
// Revision : 1.0 - initial release
// ============================================================================
module trojan_resp_analyzer #(
    parameter int N_IN = 3,
    localparam int N_PAT = 2**N_IN,
    localparam int FC_W = $clog2(N_PAT + 1),
    parameter logic [N_PAT-1:0] GOLDEN = 8'hB4
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              pat_valid,
    input  logic [N_IN-1:0]   pat_idx,
    input  logic              resp_bit,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [FC_W-1:0]   fail_count,
    output logic [N_IN-1:0]   first_fail_idx,
    output logic              seq_err,
    output logic [N_PAT-1:0]  resp_vec
);

    localparam logic [N_IN-1:0] c_last_idx = N_IN'(N_PAT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    logic [N_IN-1:0]   r_exp_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_mismatch;
    logic [FC_W-1:0]   r_fail_count;
    logic [N_IN-1:0]   r_first_fail;
    logic              r_seq_err;
    logic [N_PAT-1:0]  r_resp_vec;

    logic [N_PAT-1:0]  w_diff;
    logic [FC_W-1:0]   w_fail_cnt;
    logic [N_IN-1:0]   w_first_fail;

    // Scan high-to-low so the final assignment leaves the lowest differing index.
    always_comb begin
        w_diff       = r_resp_vec ^ GOLDEN;
        w_fail_cnt   = '0;
        w_first_fail = '0;
        for (int k = N_PAT - 1; k >= 0; k--) begin
            w_fail_cnt = w_fail_cnt + FC_W'(w_diff[k]);
            if (w_diff[k]) begin
                w_first_fail = N_IN'(k);
            end
        end
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_exp_idx    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mismatch   <= 1'b0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_seq_err    <= 1'b0;
            r_resp_vec   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_COLLECT;
                        r_exp_idx    <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_mismatch   <= 1'b0;
                        r_fail_count <= '0;
                        r_first_fail <= '0;
                        r_seq_err    <= 1'b0;
                        r_resp_vec   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (pat_valid) begin
                        if (pat_idx == r_exp_idx) begin
                            r_resp_vec[pat_idx] <= resp_bit;
                            r_exp_idx           <= r_exp_idx + 1'b1;
                            if (pat_idx == c_last_idx) begin
                                r_state <= S_COMPARE;
                            end
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                end
                S_COMPARE: begin
                    r_state      <= S_DONE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_mismatch   <= |w_diff;
                    r_fail_count <= w_fail_cnt;
                    r_first_fail <= w_first_fail;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign mismatch       = r_mismatch;
    assign fail_count     = r_fail_count;
    assign first_fail_idx = r_first_fail;
    assign seq_err        = r_seq_err;
    assign resp_vec       = r_resp_vec;

endmodule
`default_nettype wire

// File: tb/tb_trojan_resp_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trojan_resp_analyzer
// Brief    : Directed self-checking bench for trojan_resp_analyzer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trojan_resp_analyzer;

    localparam int N_IN = 3;
    localparam logic [7:0] c_golden = 8'hB4;

    logic        CK;
    logic        reset;
    logic        start;
    logic        pat_valid;
    logic [2:0]  pat_idx;
    logic        resp_bit;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [3:0]  fail_count;
    logic [2:0]  first_fail_idx;
    logic        seq_err;
    logic [7:0]  resp_vec;

    int n_checks = 0;
    int n_errors = 0;

    trojan_resp_analyzer #(
        .N_IN   (N_IN),
        .GOLDEN (c_golden)
    ) u_dut (
        .CK             (CK),
        .reset          (reset),
        .start          (start),
        .pat_valid      (pat_valid),
        .pat_idx        (pat_idx),
        .resp_bit       (resp_bit),
        .busy           (busy),
        .done           (done),
        .mismatch       (mismatch),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .seq_err        (seq_err),
        .resp_vec       (resp_vec)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [2:0] idx, input logic b);
        pat_valid = 1'b1;
        pat_idx   = idx;
        resp_bit  = b;
        tick();
        pat_valid = 1'b0;
    endtask

    task automatic sweep(input logic [7:0] vec);
        for (int k = 0; k < 8; k++) begin
            beat(3'(k), vec[k]);
        end
    endtask

    task automatic wait_done(input string tag);
        int cnt;
        cnt = 0;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic chk_results(input string tag, input logic mm, input logic [3:0] fc,
                               input logic [2:0] ff, input logic se, input logic [7:0] rv);
        chk({tag, "_done"},     32'(done),           32'd1);
        chk({tag, "_busy"},     32'(busy),           32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch),       32'(mm));
        chk({tag, "_fcount"},   32'(fail_count),     32'(fc));
        chk({tag, "_ffidx"},    32'(first_fail_idx), 32'(ff));
        chk({tag, "_seqerr"},   32'(seq_err),        32'(se));
        chk({tag, "_respvec"},  32'(resp_vec),       32'(rv));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     32'(busy),           32'd0);
        chk({tag, "_done"},     32'(done),           32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch),       32'd0);
        chk({tag, "_fcount"},   32'(fail_count),     32'd0);
        chk({tag, "_ffidx"},    32'(first_fail_idx), 32'd0);
        chk({tag, "_seqerr"},   32'(seq_err),        32'd0);
        chk({tag, "_respvec"},  32'(resp_vec),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; pat_valid = 1'b0; pat_idx = '0; resp_bit = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_all_zero("rst");

        // Golden sweep, with a beat in the start cycle that must not be captured
        start = 1'b1; pat_valid = 1'b1; pat_idx = 3'd0; resp_bit = 1'b1;
        tick();
        start = 1'b0; pat_valid = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        sweep(c_golden);
        chk("lat_compare_busy", 32'(busy), 32'd1);
        chk("lat_compare_done", 32'(done), 32'd0);
        tick();
        chk_results("golden", 1'b0, 4'd0, 3'd0, 1'b0, 8'hB4);

        // Bit 5 flipped
        do_start();
        chk("restart_done_clr", 32'(done), 32'd0);
        sweep(8'h94);
        wait_done("flip5");
        chk_results("flip5", 1'b1, 4'd1, 3'd5, 1'b0, 8'h94);

        // All inverted, then golden again replaces results
        do_start();
        sweep(8'h4B);
        wait_done("inv");
        chk_results("inv", 1'b1, 4'd8, 3'd0, 1'b0, 8'h4B);
        do_start();
        sweep(c_golden);
        wait_done("regold");
        chk_results("regold", 1'b0, 4'd0, 3'd0, 1'b0, 8'hB4);

        // Out-of-order beat with wrong data is discarded
        do_start();
        beat(3'd0, c_golden[0]);
        beat(3'd1, c_golden[1]);
        chk("seq_pre", 32'(seq_err), 32'd0);
        beat(3'd3, 1'b1);
        chk("seq_after_bad", 32'(seq_err), 32'd1);
        chk("seq_discard", 32'(resp_vec[3]), 32'd0);
        for (int k = 2; k < 8; k++) beat(3'(k), c_golden[k]);
        wait_done("seq");
        chk_results("seq", 1'b0, 4'd0, 3'd0, 1'b1, 8'hB4);

        // Reset mid-sweep
        do_start();
        for (int k = 0; k < 5; k++) beat(3'(k), ~c_golden[k]);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all_zero("midrst");
        for (int k = 5; k < 8; k++) beat(3'(k), 1'b1);
        chk("midrst_ignore_vec", 32'(resp_vec), 32'd0);
        chk("midrst_ignore_busy", 32'(busy), 32'd0);

        // Reset and start together: reset wins
        reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);

        // Start mid-collect ignored
        do_start();
        for (int k = 0; k < 4; k++) beat(3'(k), c_golden[k]);
        do_start();
        for (int k = 4; k < 8; k++) beat(3'(k), c_golden[k]);
        wait_done("midstart");
        chk_results("midstart", 1'b0, 4'd0, 3'd0, 1'b0, 8'hB4);

        // Beats in DONE ignored
        beat(3'd0, 1'b1);
        beat(3'd3, 1'b1);
        chk_results("done_ign", 1'b0, 4'd0, 3'd0, 1'b0, 8'hB4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
